// File: rtl/imm_pkg.sv
// Shared encodings for the pipelined RISC-V immediate generator.
// Format selectors, base opcodes and the entry record used to describe one result.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I     = 3'b000,
      IMM_S     = 3'b001,
      IMM_B     = 3'b010,
      IMM_U     = 3'b011,
      IMM_J     = 3'b100,
      IMM_AUTO  = 3'b101,
      IMM_SHAMT = 3'b110,
      IMM_RSVD  = 3'b111
   } imm_op_e;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam int unsigned XLEN_MAX = 64;

   typedef struct packed {
      logic [XLEN_MAX-1:0] imm;
      logic                illegal;
   } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction: (format, instruction) -> XLEN-bit immediate.
// AUTO resolves the format from the opcode; unknown opcodes and the reserved op flag illegal.
module imm_decode
   import imm_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]      i_op,
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm,
   output logic            o_illegal
);

   localparam int unsigned ShW = (XLEN == 64) ? 6 : 5;

   imm_op_e         w_fmt;
   logic [XLEN-1:0] w_sext;

   assign w_sext = {XLEN{i_instr[31]}};

   always_comb begin
      w_fmt = imm_op_e'(i_op);
      if (w_fmt == IMM_AUTO) begin
         case (i_instr[6:0])
            OPC_OP_IMM: w_fmt = (i_instr[14:12] == 3'b001 || i_instr[14:12] == 3'b101)
                                ? IMM_SHAMT : IMM_I;
            OPC_LOAD, OPC_JALR: w_fmt = IMM_I;
            OPC_STORE:          w_fmt = IMM_S;
            OPC_BRANCH:         w_fmt = IMM_B;
            OPC_LUI, OPC_AUIPC: w_fmt = IMM_U;
            OPC_JAL:            w_fmt = IMM_J;
            default:            w_fmt = IMM_RSVD;
         endcase
      end
   end

   always_comb begin
      o_imm     = '0;
      o_illegal = 1'b0;
      case (w_fmt)
         IMM_I: o_imm = {w_sext[XLEN-1:12], i_instr[31:20]};
         IMM_S: o_imm = {w_sext[XLEN-1:12], i_instr[31:25], i_instr[11:7]};
         IMM_B: o_imm = {w_sext[XLEN-1:12], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U: begin
            // Sign fill above bit 31 only matters for XLEN=64.
            o_imm       = w_sext;
            o_imm[31:0] = {i_instr[31:12], 12'b0};
         end
         IMM_J: o_imm = {w_sext[XLEN-1:20], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         IMM_SHAMT: o_imm = XLEN'(i_instr[20 +: ShW]);
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a valid/ready interface and a 2-entry skid buffer
// (main M drives the outputs, skid K absorbs one extra request), plus an illegal-request counter.
module imm_gen_pipe
   import imm_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   logic [XLEN-1:0]  w_dec_imm;
   logic             w_dec_ill;
   logic             w_acc;
   logic             w_pop;

   logic             r_m_vld;
   logic [XLEN-1:0]  r_m_imm;
   logic             r_m_ill;
   logic             r_k_vld;
   logic [XLEN-1:0]  r_k_imm;
   logic             r_k_ill;
   logic [CNT_W-1:0] r_cnt;

   imm_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .i_op      (in_op),
      .i_instr   (in_instr),
      .o_imm     (w_dec_imm),
      .o_illegal (w_dec_ill)
   );

   // in_ready depends only on K, so out_ready never reaches it combinationally.
   assign in_ready = !r_k_vld;
   assign w_acc    = in_valid && in_ready;
   assign w_pop    = r_m_vld && out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_m_vld <= 1'b0;
         r_m_imm <= '0;
         r_m_ill <= 1'b0;
         r_k_vld <= 1'b0;
         r_k_imm <= '0;
         r_k_ill <= 1'b0;
      end else if (w_pop && r_k_vld) begin
         r_m_imm <= r_k_imm;
         r_m_ill <= r_k_ill;
         r_k_vld <= 1'b0;
      end else if (w_acc && (!r_m_vld || w_pop)) begin
         r_m_vld <= 1'b1;
         r_m_imm <= w_dec_imm;
         r_m_ill <= w_dec_ill;
      end else if (w_acc) begin
         r_k_vld <= 1'b1;
         r_k_imm <= w_dec_imm;
         r_k_ill <= w_dec_ill;
      end else if (w_pop) begin
         r_m_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_acc && w_dec_ill && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign out_valid   = r_m_vld;
   assign out_imm     = r_m_imm;
   assign out_illegal = r_m_ill;
   assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (XLEN 32, XLEN 64, CNT_W 2) share one stimulus
// stream and are compared every cycle against an arithmetic reference and a FIFO model.
module tb_imm_gen_pipe;
   import imm_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  in_op = 3'b000;
   logic [31:0] in_instr = 32'h0;
   logic        out_ready = 1'b0;

   logic        rdy_32, rdy_64, rdy_c2;
   logic        vld_32, vld_64, vld_c2;
   logic [31:0] imm_32, imm_c2;
   logic [63:0] imm_64;
   logic        ill_32, ill_64, ill_c2;
   logic [7:0]  cnt_32, cnt_64;
   logic [1:0]  cnt_c2;

   int n_checks = 0;
   int n_fail   = 0;

   imm_entry_t q32[$];
   imm_entry_t q64[$];
   int         m_cnt8;
   int         m_cnt2;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .CNT_W(8)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_32), .in_op(in_op),
      .in_instr(in_instr), .out_valid(vld_32), .out_ready(out_ready), .out_imm(imm_32),
      .out_illegal(ill_32), .illegal_cnt(cnt_32));

   imm_gen_pipe #(.XLEN(64), .CNT_W(8)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_64), .in_op(in_op),
      .in_instr(in_instr), .out_valid(vld_64), .out_ready(out_ready), .out_imm(imm_64),
      .out_illegal(ill_64), .illegal_cnt(cnt_64));

   imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u_dutc2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c2), .in_op(in_op),
      .in_instr(in_instr), .out_valid(vld_c2), .out_ready(out_ready), .out_imm(imm_c2),
      .out_illegal(ill_c2), .illegal_cnt(cnt_c2));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // Immediate value computed from the field weights, then wrapped to the target width.
   function automatic imm_entry_t ref_imm(input logic [2:0] op, input logic [31:0] ins,
                                          input bit x64);
      imm_entry_t r;
      longint     v;
      int         fmt;
      v         = 0;
      r.illegal = 1'b0;
      fmt       = int'(op);
      if (fmt == 5) begin
         case (ins[6:0])
            7'h13:        fmt = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 6 : 0;
            7'h03, 7'h67: fmt = 0;
            7'h23:        fmt = 1;
            7'h63:        fmt = 2;
            7'h37, 7'h17: fmt = 3;
            7'h6F:        fmt = 4;
            default:      fmt = 7;
         endcase
      end
      case (fmt)
         0: v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
         1: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0);
         2: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
                - (ins[31] ? 4096 : 0);
         3: v = longint'(ins[31:12]) * 4096 - (ins[31] ? longint'(64'h1_0000_0000) : 0);
         4: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                + longint'(ins[30:21]) * 2 - (ins[31] ? 1048576 : 0);
         6: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
         default: r.illegal = 1'b1;
      endcase
      r.imm = x64 ? 64'(v) : {32'h0, v[31:0]};
      return r;
   endfunction

   task automatic check_all();
      chk("in_ready32", rdy_32, q32.size() < 2);
      chk("in_ready64", rdy_64, q64.size() < 2);
      chk("in_readyc2", rdy_c2, q32.size() < 2);
      chk("out_valid32", vld_32, q32.size() > 0);
      chk("out_valid64", vld_64, q64.size() > 0);
      chk("out_validc2", vld_c2, q32.size() > 0);
      if (q32.size() > 0) begin
         chk("out_imm32", imm_32, q32[0].imm);
         chk("out_illegal32", ill_32, q32[0].illegal);
         chk("out_immc2", imm_c2, q32[0].imm);
         chk("out_illegalc2", ill_c2, q32[0].illegal);
      end
      if (q64.size() > 0) begin
         chk("out_imm64", imm_64, q64[0].imm);
         chk("out_illegal64", ill_64, q64[0].illegal);
      end
      chk("illegal_cnt32", cnt_32, m_cnt8);
      chk("illegal_cnt64", cnt_64, m_cnt8);
      chk("illegal_cntc2", cnt_c2, m_cnt2);
   endtask

   // One cycle: check current outputs, drive new inputs, advance the model past the clock edge.
   task automatic step(input logic v, input logic [2:0] op, input logic [31:0] ins,
                       input logic ordy);
      bit pop, push;
      imm_entry_t e32, e64;
      check_all();
      in_valid  = v;
      in_op     = op;
      in_instr  = ins;
      out_ready = ordy;
      pop  = (q32.size() > 0) && ordy;
      push = v && (q32.size() < 2);
      e32  = ref_imm(op, ins, 1'b0);
      e64  = ref_imm(op, ins, 1'b1);
      if (pop) begin
         void'(q32.pop_front());
         void'(q64.pop_front());
      end
      if (push) begin
         q32.push_back(e32);
         q64.push_back(e64);
         if (e32.illegal) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
      @(negedge clk);
   endtask

   task automatic model_reset();
      q32.delete();
      q64.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
   endtask

   logic [6:0] opcodes [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

   initial begin
      logic [31:0] ins;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_valid", vld_32, 1'b0);
      chk("reset_imm", imm_32, 32'h0);
      chk("reset_illegal", ill_32, 1'b0);
      chk("reset_cnt", cnt_32, 8'h0);
      rst = 1'b1;
      @(negedge clk);

      step(1'b1, 3'b000, 32'hFFF0_0093, 1'b1);
      chk("plan_I32", imm_32, 32'hFFFF_FFFF);
      chk("plan_I64", imm_64, 64'hFFFF_FFFF_FFFF_FFFF);
      step(1'b1, 3'b010, 32'hFE00_0EE3, 1'b1);
      chk("plan_B", imm_32, 32'hFFFF_FFFC);
      step(1'b1, 3'b011, 32'h1234_50B7, 1'b1);
      chk("plan_U", imm_32, 32'h1234_5000);
      step(1'b1, 3'b101, 32'h0080_006F, 1'b1);
      chk("plan_auto_J", imm_32, 32'h0000_0008);
      step(1'b1, 3'b101, 32'h0000_0033, 1'b1);
      chk("plan_auto_bad_imm", imm_32, 32'h0);
      chk("plan_auto_bad_ill", ill_32, 1'b1);
      chk("plan_auto_bad_cnt", cnt_32, 8'd1);
      step(1'b1, 3'b110, 32'h03F0_D093, 1'b1);
      chk("plan_shamt64", imm_64, 64'h3F);
      chk("plan_shamt32", imm_32, 32'h1F);
      step(1'b0, 3'b000, 32'h0, 1'b1);

      // Backpressure: two accepted, third held until the skid drains.
      step(1'b1, 3'b000, 32'h0010_0093, 1'b0);
      step(1'b1, 3'b000, 32'h0020_0093, 1'b0);
      chk("bp_full_ready", rdy_32, 1'b0);
      step(1'b1, 3'b000, 32'h0030_0093, 1'b0);
      step(1'b1, 3'b000, 32'h0030_0093, 1'b0);
      chk("bp_head_held", imm_32, 32'h1);
      step(1'b1, 3'b000, 32'h0030_0093, 1'b1);
      chk("bp_second", imm_32, 32'h2);
      step(1'b1, 3'b000, 32'h0030_0093, 1'b1);
      step(1'b0, 3'b000, 32'h0, 1'b1);
      chk("bp_third", imm_32, 32'h3);
      step(1'b0, 3'b000, 32'h0, 1'b1);

      for (int i = 0; i < 5; i++) step(1'b1, 3'b111, $urandom, 1'b1);
      chk("sat_cnt2", cnt_c2, 2'd3);
      step(1'b0, 3'b000, 32'h0, 1'b1);

      for (int i = 0; i < 400; i++) begin
         ins = $urandom;
         if ($urandom_range(0, 1) == 1) ins[6:0] = opcodes[$urandom_range(0, 8)];
         step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ins,
              1'($urandom_range(0, 2) != 0));
      end

      // Reset with both entries occupied.
      step(1'b1, 3'b111, 32'h0, 1'b0);
      step(1'b1, 3'b111, 32'h0, 1'b0);
      chk("prerst_full", rdy_32, 1'b0);
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
      chk("rst_async_valid", vld_32, 1'b0);
      chk("rst_async_cnt", cnt_32, 8'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("postrst_ready", rdy_32, 1'b1);
      chk("postrst_valid", vld_64, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 3'b100, $urandom, 1'($urandom_range(0, 1)));
      check_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the combinational immediate extender.
- Sits between instruction fetch/decode and the execute stage of the RISC-V core.
- Takes a 32-bit instruction plus a format selector. Supports I/S/B/U/J, shift-amount and auto-decode-from-opcode modes.
- Produces a sign- or zero-extended XLEN-bit immediate through a valid/ready handshake with a 2-entry skid buffer. Also counts illegal requests.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- CNT_W, 8, width of saturating illegal-request counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept request.
- in_op  in  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 AUTO, 110 SHAMT, 111 reserved.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_imm  out  XLEN  extended immediate.
- out_illegal  out  1  request was illegal (reserved op, or AUTO with non-immediate opcode).
- illegal_cnt  out  CNT_W  saturating count of illegal requests accepted.

Behaviour:
- Reset (rst low, asynchronous): out_valid=0, out_imm=0, out_illegal=0, illegal_cnt=0, skid empty, in_ready=1 after release.
  - Reset mid-transfer discards both entries; no result is emitted for them.
- Extension rules; s = instr[31] replicated to XLEN:
  - I: s, instr[31:20].
  - S: s, instr[31:25], instr[11:7].
  - B: s, instr[7], instr[30:25], instr[11:8], 0.
  - U: s above bit 31, instr[31:12], 12'b0. For XLEN=32 this is exactly instr[31:12]<<12.
  - J: s, instr[19:12], instr[20], instr[30:21], 0.
  - SHAMT: zero-extended instr[24:20] if XLEN=32, instr[25:20] if XLEN=64.
  - Reserved (111): imm=0, illegal=1.
- AUTO mode maps instr[6:0]:
  - 0010011 → I, except funct3 instr[14:12] 001/101 → SHAMT.
  - 0000011, 1100111 → I.
  - 0100011 → S.
  - 1100011 → B.
  - 0110111, 0010111 → U.
  - 1101111 → J.
  - Any other opcode → imm=0, illegal=1.
- Decode is combinational on the input side; the result is stored in registers, so outputs are fully registered.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - out_valid/out_imm/out_illegal are held stable while out_valid & !out_ready.
- Storage: main register M (drives outputs) and skid register K.
  - in_ready = !K.valid (registered, no combinational path from out_ready).
  - Accept while M empty, or M being consumed that cycle → load M. Result visible the next cycle: latency 1, throughput 1/cycle.
  - Accept while M full and not consumed → load K.
  - K valid and M consumed → M←K, K cleared. In that cycle in_ready=0, so no simultaneous input load.
  - Full (M and K valid, out_ready=0): in_ready=0; inputs are ignored.
  - Empty: out_valid=0; out_imm holds its last value (don't-care).
- illegal_cnt increments on each accepted illegal request and saturates at 2^CNT_W−1 (no wrap).

Decomposition:
- Package imm_pkg holds:
  - op encodings (IMM_I … IMM_RSVD);
  - RISC-V opcode constants;
  - struct {imm, illegal} for an entry.
- Optional sub-module imm_decode: combinational, XLEN-parametrised, (op, instr) → (imm, illegal).
- imm_gen_pipe instantiates imm_decode and owns the skid buffer and counter.

Test Plan:
- XLEN=32, op=000, instr=0xFFF00093, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- op=010, instr=0xFE000EE3 → out_imm=0xFFFFFFFC.
- op=011, instr=0x123450B7 → out_imm=0x12345000.
- op=101, instr=0x0080006F → out_imm=0x00000008.
- op=101, instr=0x00000033 → out_imm=0, out_illegal=1, illegal_cnt=1.
- out_ready=0, push three valid I requests back-to-back:
  - first two accepted; in_ready=0 from the cycle after the second;
  - third held.
  - Raise out_ready: results emitted in order, one per cycle, with no loss or duplication.
- XLEN=64, op=000, instr=0xFFF00093 → out_imm=0xFFFFFFFFFFFFFFFF. Same configuration, op=110, instr=0x03F0D093 → out_imm=0x3F.
- Assert rst with M and K full → out_valid=0 and in_ready=1 after release; illegal_cnt=0.
- CNT_W=2: five illegal requests → illegal_cnt stays 3.
